// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller with standard or first-word-fall-through reads,
// registered status flags and a saturating count of rejected writes.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH          = 32,
  parameter int ADDR_WIDTH          = 9,
  parameter int ALMOST_FULL_OFFSET  = 128,
  parameter int ALMOST_EMPTY_OFFSET = 128,
  parameter int FWFT                = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  WriteEN,
  input  logic [DATA_WIDTH-1:0] data_input,
  input  logic                  ReadEN,
  output logic [DATA_WIDTH-1:0] data_output,
  output logic                  valid,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  writeERR,
  output logic                  readERR,
  output logic [ADDR_WIDTH:0]   level,
  output logic [15:0]           drop_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LVL_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_LVL = LVL_W'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_LVL    = LVL_W'(DEPTH - ALMOST_FULL_OFFSET);
  localparam logic [ADDR_WIDTH:0]   AE_LVL    = LVL_W'(ALMOST_EMPTY_OFFSET);
  localparam logic [ADDR_WIDTH:0]   LVL_ZERO  = {LVL_W{1'b0}};
  localparam logic [ADDR_WIDTH:0]   LVL_ONE   = LVL_W'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  if (ADDR_WIDTH < 2 || ALMOST_FULL_OFFSET < 0 || ALMOST_FULL_OFFSET >= DEPTH ||
      ALMOST_EMPTY_OFFSET < 0 || ALMOST_EMPTY_OFFSET >= DEPTH) begin : g_param_check
    $error("sync_fifo_ctrl: illegal ADDR_WIDTH or almost-flag offset");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  full_q, full_d;
  logic                  almost_full_q, almost_full_d;
  logic                  empty_q, empty_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  write_err_q, write_err_d;
  logic                  read_err_q, read_err_d;
  logic [15:0]           drop_q, drop_d;

  logic wr_acc;
  logic rd_acc;
  logic load;

  // Request acceptance; in FWFT mode the output register is refilled from memory
  // whenever it is empty or being popped.
  always_comb begin
    wr_acc = WriteEN && !full_q;
    if (FWFT != 0) begin
      rd_acc = ReadEN && valid_q;
      load   = (mem_cnt_q != LVL_ZERO) && (!valid_q || rd_acc);
    end else begin
      rd_acc = ReadEN && !empty_q;
      load   = rd_acc;
    end
  end

  // Next-state computation for pointers, counts, output word and flags.
  always_comb begin
    wr_ptr_d  = wr_acc ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d  = load ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    mem_cnt_d = mem_cnt_q + LVL_W'(wr_acc) - LVL_W'(load);
    data_d    = load ? mem_q[rd_ptr_q] : data_q;

    // A word written into an empty FWFT FIFO is only counted once it is presented.
    if (FWFT != 0) begin
      if (load) begin
        valid_d = 1'b1;
      end else if (rd_acc) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
      level_d = valid_d ? (mem_cnt_d + LVL_ONE) : LVL_ZERO;
      empty_d = !valid_d;
    end else begin
      valid_d = load;
      level_d = mem_cnt_d;
      empty_d = (level_d == LVL_ZERO);
    end

    full_d         = (level_d == DEPTH_LVL);
    almost_full_d  = (level_d >= AF_LVL);
    almost_empty_d = (level_d <= AE_LVL);
    write_err_d    = WriteEN && full_q;
    read_err_d     = ReadEN && empty_q;

    if (write_err_d && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q       <= {ADDR_WIDTH{1'b0}};
      mem_cnt_q      <= LVL_ZERO;
      level_q        <= LVL_ZERO;
      data_q         <= {DATA_WIDTH{1'b0}};
      valid_q        <= 1'b0;
      full_q         <= 1'b0;
      almost_full_q  <= 1'b0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      write_err_q    <= 1'b0;
      read_err_q     <= 1'b0;
      drop_q         <= 16'd0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      mem_cnt_q      <= mem_cnt_d;
      level_q        <= level_d;
      data_q         <= data_d;
      valid_q        <= valid_d;
      full_q         <= full_d;
      almost_full_q  <= almost_full_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      write_err_q    <= write_err_d;
      read_err_q     <= read_err_d;
      drop_q         <= drop_d;
    end
  end

  // Storage array; never cleared, reset only discards it via the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem_q[wr_ptr_q] <= data_input;
    end
  end

  assign data_output  = data_q;
  assign valid        = valid_q;
  assign full         = full_q;
  assign almost_full  = almost_full_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign writeERR     = write_err_q;
  assign readERR      = read_err_q;
  assign level        = level_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl: one standard-mode and one FWFT instance,
// both DEPTH=16 with almost offsets of 4.
module tb_sync_fifo_ctrl;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic          s_rst, s_wen, s_ren;
  logic [31:0]   s_din, s_dout;
  logic          s_valid, s_full, s_afull, s_empty, s_aempty, s_werr, s_rerr;
  logic [AW:0]   s_level;
  logic [15:0]   s_drop;

  logic          f_rst, f_wen, f_ren;
  logic [31:0]   f_din, f_dout;
  logic          f_valid, f_full, f_afull, f_empty, f_aempty, f_werr, f_rerr;
  logic [AW:0]   f_level;
  logic [15:0]   f_drop;

  logic [31:0] s_exp[$];
  logic [31:0] f_exp[$];
  logic [31:0] s_model[$];

  sync_fifo_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .ALMOST_FULL_OFFSET(4),
                   .ALMOST_EMPTY_OFFSET(4), .FWFT(0)) u_std (
    .clk(clk), .rst(s_rst), .WriteEN(s_wen), .data_input(s_din), .ReadEN(s_ren),
    .data_output(s_dout), .valid(s_valid), .full(s_full), .almost_full(s_afull),
    .empty(s_empty), .almost_empty(s_aempty), .writeERR(s_werr), .readERR(s_rerr),
    .level(s_level), .drop_count(s_drop)
  );

  sync_fifo_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .ALMOST_FULL_OFFSET(4),
                   .ALMOST_EMPTY_OFFSET(4), .FWFT(1)) u_fwft (
    .clk(clk), .rst(f_rst), .WriteEN(f_wen), .data_input(f_din), .ReadEN(f_ren),
    .data_output(f_dout), .valid(f_valid), .full(f_full), .almost_full(f_afull),
    .empty(f_empty), .almost_empty(f_aempty), .writeERR(f_werr), .readERR(f_rerr),
    .level(f_level), .drop_count(f_drop)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {full, almost_full, empty, almost_empty, valid, writeERR, readERR}
  function automatic logic [31:0] s_flags();
    return 32'({s_full, s_afull, s_empty, s_aempty, s_valid, s_werr, s_rerr});
  endfunction

  function automatic logic [31:0] f_flags();
    return 32'({f_full, f_afull, f_empty, f_aempty, f_valid, f_werr, f_rerr});
  endfunction

  // Standard-mode monitor: every valid cycle must deliver the next expected word.
  always @(negedge clk) begin
    if (s_valid === 1'b1) begin
      if (s_exp.size() == 0) check("std_unexpected_valid", 32'(s_valid), 32'd0);
      else                   check("std_read_data", s_dout, s_exp.pop_front());
    end
  end

  // FWFT monitor: the presented word is compared when it is popped.
  always @(negedge clk) begin
    if (f_valid === 1'b1 && f_ren === 1'b1) begin
      if (f_exp.size() == 0) check("fwft_unexpected_pop", 32'(f_valid), 32'd0);
      else                   check("fwft_read_data", f_dout, f_exp.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_rst = 1'b1; s_wen = 1'b0; s_ren = 1'b0; s_din = 32'd0;
    f_rst = 1'b1; f_wen = 1'b0; f_ren = 1'b0; f_din = 32'd0;
    tick();
    tick();
    s_rst = 1'b0;
    f_rst = 1'b0;
    check("std_reset_flags", s_flags(), 32'h18);
    check("std_reset_level", 32'(s_level), 32'd0);
    check("std_reset_data", s_dout, 32'd0);
    check("std_reset_drop", 32'(s_drop), 32'd0);
    check("fwft_reset_flags", f_flags(), 32'h18);
    check("fwft_reset_drop", 32'(f_drop), 32'd0);

    // read on empty
    s_ren = 1'b1; tick(); s_ren = 1'b0;
    check("rd_empty_flags", s_flags(), 32'h19);
    check("rd_empty_level", 32'(s_level), 32'd0);
    check("rd_empty_data", s_dout, 32'd0);
    tick();
    check("rd_err_pulse_end", 32'(s_rerr), 32'd0);

    // fill to full, with almost-flag thresholds
    for (int i = 1; i <= 16; i++) begin
      s_wen = 1'b1; s_din = 32'(i); s_model.push_back(32'(i));
      tick();
      check("fill_level", 32'(s_level), 32'(i));
      check("fill_almost", 32'({s_aempty, s_afull}), 32'({(i <= 4), (i >= 12)}));
    end
    s_din = 32'h11;
    tick();
    s_wen = 1'b0;
    check("overflow_flags", s_flags(), 32'h62);
    check("overflow_drop", 32'(s_drop), 32'd1);
    check("overflow_level", 32'(s_level), 32'd16);
    tick();
    check("overflow_pulse_end", s_flags(), 32'h60);

    // drain in order
    for (int j = 1; j <= 16; j++) begin
      s_ren = 1'b1; s_exp.push_back(s_model.pop_front());
      tick();
      check("drain_level", 32'(s_level), 32'(16 - j));
      check("drain_almost", 32'({s_aempty, s_afull}), 32'({((16 - j) <= 4), ((16 - j) >= 12)}));
    end
    s_ren = 1'b0;
    check("drain_empty", 32'(s_empty), 32'd1);
    tick();
    check("idle_flags", s_flags(), 32'h18);
    check("idle_hold_data", s_dout, 32'h10);

    // streaming read+write at level 8 across three wraps
    for (int i = 0; i < 8; i++) begin
      s_wen = 1'b1; s_din = 32'h100 + 32'(i); s_model.push_back(s_din);
      tick();
    end
    for (int i = 0; i < 48; i++) begin
      s_wen = 1'b1; s_ren = 1'b1; s_din = 32'h200 + 32'(i);
      s_exp.push_back(s_model.pop_front());
      s_model.push_back(s_din);
      tick();
      check("stream_level", 32'(s_level), 32'd8);
      check("stream_errors", 32'({s_werr, s_rerr}), 32'd0);
    end
    s_ren = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_wen = 1'b1; s_din = 32'h300 + 32'(i); s_model.push_back(s_din);
      tick();
    end
    s_wen = 1'b0;
    check("pre_reset_level", 32'(s_level), 32'd10);

    // reset mid-stream with requests pending
    s_rst = 1'b1; s_wen = 1'b1; s_ren = 1'b1; s_din = 32'hDEAD;
    tick();
    s_rst = 1'b0; s_wen = 1'b0; s_ren = 1'b0;
    s_model.delete();
    check("midrst_flags", s_flags(), 32'h18);
    check("midrst_level", 32'(s_level), 32'd0);
    check("midrst_data", s_dout, 32'd0);
    check("midrst_drop", 32'(s_drop), 32'd0);
    s_wen = 1'b1; s_din = 32'h7; tick(); s_wen = 1'b0;
    check("post_rst_level", 32'(s_level), 32'd1);
    s_ren = 1'b1; s_exp.push_back(32'h7); tick(); s_ren = 1'b0;
    check("post_rst_flags", s_flags(), 32'h1C);
    check("post_rst_data", s_dout, 32'h7);

    // FWFT: single word latency
    f_wen = 1'b1; f_din = 32'hA5; f_exp.push_back(32'hA5);
    tick();
    f_wen = 1'b0;
    check("fwft_k_state", 32'({f_valid, f_empty}), 32'd1);
    check("fwft_k_level", 32'(f_level), 32'd0);
    tick();
    check("fwft_k1_state", 32'({f_valid, f_empty}), 32'd2);
    check("fwft_k1_data", f_dout, 32'hA5);
    check("fwft_k1_level", 32'(f_level), 32'd1);
    f_ren = 1'b1; tick(); f_ren = 1'b0;
    check("fwft_pop_state", 32'({f_valid, f_empty}), 32'd1);
    check("fwft_pop_level", 32'(f_level), 32'd0);

    // FWFT: burst of three then back-to-back pops
    for (int i = 0; i < 3; i++) begin
      f_wen = 1'b1; f_din = 32'(32'h11 * (i + 1)); f_exp.push_back(f_din);
      tick();
    end
    f_wen = 1'b0;
    check("fwft_burst_level", 32'(f_level), 32'd3);
    check("fwft_burst_head", f_dout, 32'h11);
    f_ren = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    f_ren = 1'b0;
    check("fwft_drained_flags", f_flags(), 32'h18);
    check("fwft_drained_level", 32'(f_level), 32'd0);
    f_ren = 1'b1; tick(); f_ren = 1'b0;
    check("fwft_rd_empty_flags", f_flags(), 32'h19);

    tick();
    check("std_scoreboard_drained", 32'(s_exp.size()), 32'd0);
    check("fwft_scoreboard_drained", 32'(f_exp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
